pulse_pc_seq: RTL and testbench
===============================

// Module: pulse_pc_seq
// PURPOSE
//  Multi-channel program-counter sequencer for the pulse circuit; supersedes the single-channel PC register.
//  Each channel owns an independent PC and a start/stop FSM.
//  Supports sequential step, absolute jump, and nested hardware loops (per-channel loop stack).
//  Feeds per-channel pulse instruction memory read addresses; the decoder drives update_pc/op.
// PARAMETERS
//  PC_WIDTH    11  PC width; PC arithmetic is modulo 2^PC_WIDTH
//  NUM_CH      4   number of independent pulse channels
//  LOOP_DEPTH  2   loop-stack entries per channel (max nesting)
//  CNT_WIDTH   8   loop iteration counter width
//  RESET_PC    0   PC value in reset and IDLE
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous, active-high reset
//  start        in   NUM_CH             per-channel arm request
//  stop         in   NUM_CH             per-channel abort, return to IDLE
//  update_pc    in   NUM_CH             per-channel advance strobe
//  op           in   2*NUM_CH           per-channel op: 00 SEQ, 01 JUMP, 10 LOOP_BEGIN, 11 LOOP_END
//  jump_target  in   PC_WIDTH*NUM_CH    per-channel JUMP destination
//  loop_count   in   CNT_WIDTH*NUM_CH   extra iterations for LOOP_BEGIN (body runs count+1 times)
//  PC           out  PC_WIDTH*NUM_CH    per-channel registered PC
//  running      out  NUM_CH             channel in FIRST or RUN
//  loop_err     out  NUM_CH             sticky loop-stack overflow/underflow flag
// BEHAVIOUR
//  Reset: all PC=RESET_PC, running=0, loop_err=0, stacks empty, FSM=IDLE. Reset takes effect mid-operation.
//  Channels are fully independent; slice i of each bus belongs to channel i.
//  FSM per channel:
//   - IDLE: PC held at RESET_PC; update_pc ignored; start -> FIRST.
//   - FIRST: running=1. The first update_pc is swallowed (PC unchanged) -> RUN.
//     This covers the fetch-priming cycle.
//   - RUN: each update_pc executes op (below); start is ignored.
//   - Any state: stop -> IDLE next cycle: PC=RESET_PC, stack cleared, running=0, loop_err kept.
//   - stop and start in the same cycle: stop wins.
//  Latency: PC is registered and reflects an update_pc sampled at edge N after edge N (visible in cycle N+1).
//  Ops (RUN, update_pc=1):
//   - SEQ: PC <= PC+1; wraps from 2^PC_WIDTH-1 to 0 with no flag.
//   - JUMP: PC <= jump_target.
//   - LOOP_BEGIN: push {PC+1, loop_count}; PC <= PC+1.
//     If the stack is full: no push, set loop_err, PC <= PC+1.
//   - LOOP_END, stack empty: set loop_err, PC <= PC+1.
//   - LOOP_END, top.cnt==0: pop, PC <= PC+1 (loop exit).
//   - LOOP_END, top.cnt>0: top.cnt <= top.cnt-1, PC <= top.addr.
//  update_pc=0: PC, stack and FSM state hold (stall).
//  loop_err clears only on rst.
// STRUCTURE
//  pulse_pc_pkg: op encoding constants (OP_SEQ, OP_JUMP, OP_LOOP_BEGIN, OP_LOOP_END).
//  pulse_pc_pkg: channel state encoding (ST_IDLE, ST_FIRST, ST_RUN).
//  Sub-module pulse_pc_loop_stack: LIFO of LOOP_DEPTH x {PC_WIDTH addr, CNT_WIDTH cnt}.
//   Ports: push, pop, dec_top, clear, full, empty, top_addr, top_cnt.
//   Simultaneous push and pop never occur.
//  Top level: generate loop over NUM_CH, one FSM + PC register + stack per channel.
// TESTING
//  1. Reset, start ch0, 4x update_pc op=SEQ -> PC0 = 0,0,1,2,3 (first swallowed); other channels stay 0, running=0001.
//  2. ch1 running at PC=5, JUMP target=0x40 -> PC1=0x40 next cycle.
//     PC=0x7FF then SEQ -> PC=0.
//  3. ch2 at PC=10: LOOP_BEGIN count=2, SEQ, LOOP_END.
//     -> PC sequence 11,12,11,12,11,12,13 (body x3); stack empty after.
//  4. Nested: LOOP_BEGIN c=1 @0, LOOP_BEGIN c=1 @1, LOOP_END @2, LOOP_END @3.
//     -> inner body 4 times total, ends PC=4; 3rd nested push with LOOP_DEPTH=2 sets loop_err.
//  5. LOOP_END with empty stack -> loop_err=1, PC+1.
//     stop with start same cycle -> IDLE, PC=RESET_PC, loop_err still 1.
//  6. rst asserted mid-loop on all channels -> next cycle all PC=0, running=0, loop_err=0; update_pc then ignored.

Source files
------------

// File: rtl/pulse_pc_pkg.sv
// Shared encodings for the pulse PC sequencer: op codes and per-channel FSM states.
package pulse_pc_pkg;

    localparam logic [1:0] OP_SEQ        = 2'b00;
    localparam logic [1:0] OP_JUMP       = 2'b01;
    localparam logic [1:0] OP_LOOP_BEGIN = 2'b10;
    localparam logic [1:0] OP_LOOP_END   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } ch_state_t;

endpackage

// File: rtl/pulse_pc_loop_stack.sv
// Per-channel LIFO of {return address, remaining iterations} for nested hardware loops.
module pulse_pc_loop_stack #(
    parameter int PC_WIDTH   = 11,
    parameter int CNT_WIDTH  = 8,
    parameter int LOOP_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 dec_top,
    input  logic                 clear,
    input  logic [PC_WIDTH-1:0]  push_addr,
    input  logic [CNT_WIDTH-1:0] push_cnt,
    output logic                 full,
    output logic                 empty,
    output logic [PC_WIDTH-1:0]  top_addr,
    output logic [CNT_WIDTH-1:0] top_cnt
);

    localparam int SP_W = $clog2(LOOP_DEPTH + 1);

    logic [SP_W-1:0]      sp;
    logic [SP_W-1:0]      top_idx;
    logic [PC_WIDTH-1:0]  addr_mem [LOOP_DEPTH];
    logic [CNT_WIDTH-1:0] cnt_mem  [LOOP_DEPTH];

    // When empty, top_idx wraps to an index no entry matches, so top reads as zero.
    assign top_idx = sp - SP_W'(1);
    assign full    = (sp == SP_W'(LOOP_DEPTH));
    assign empty   = (sp == '0);

    always_comb begin
        top_addr = '0;
        top_cnt  = '0;
        for (int i = 0; i < LOOP_DEPTH; i++) begin
            if (SP_W'(i) == top_idx) begin
                top_addr = addr_mem[i];
                top_cnt  = cnt_mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LOOP_DEPTH; i++) begin
            if (push && !full && SP_W'(i) == sp) begin
                addr_mem[i] <= push_addr;
                cnt_mem[i]  <= push_cnt;
            end else if (dec_top && !empty && SP_W'(i) == top_idx) begin
                cnt_mem[i] <= cnt_mem[i] - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_pc_seq.sv
// Multi-channel pulse program-counter sequencer: per channel an arm/run FSM, a PC
// register and a loop stack; slice i of every bus belongs to channel i.
module pulse_pc_seq
    import pulse_pc_pkg::*;
#(
    parameter int PC_WIDTH   = 11,
    parameter int NUM_CH     = 4,
    parameter int LOOP_DEPTH = 2,
    parameter int CNT_WIDTH  = 8,
    parameter int RESET_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             start,
    input  logic [NUM_CH-1:0]             stop,
    input  logic [NUM_CH-1:0]             update_pc,
    input  logic [2*NUM_CH-1:0]           op,
    input  logic [PC_WIDTH*NUM_CH-1:0]    jump_target,
    input  logic [CNT_WIDTH*NUM_CH-1:0]   loop_count,
    output logic [PC_WIDTH*NUM_CH-1:0]    PC,
    output logic [NUM_CH-1:0]             running,
    output logic [NUM_CH-1:0]             loop_err
);

    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);

    // Per-channel FSM state, kept as a named array so checkers can observe it.
    ch_state_t ch_state [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t            state_q, state_d;
        logic [PC_WIDTH-1:0]  pc_q, pc_d, pc_inc;
        logic                 err_q, err_d;
        logic                 push, pop, dec_top, clear;
        logic                 full, empty;
        logic [PC_WIDTH-1:0]  top_addr;
        logic [CNT_WIDTH-1:0] top_cnt;

        assign pc_inc = pc_q + PC_WIDTH'(1);

        pulse_pc_loop_stack #(
            .PC_WIDTH   (PC_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .LOOP_DEPTH (LOOP_DEPTH)
        ) u_stack (
            .clk       (clk),
            .rst       (rst),
            .push      (push),
            .pop       (pop),
            .dec_top   (dec_top),
            .clear     (clear),
            .push_addr (pc_inc),
            .push_cnt  (loop_count[i*CNT_WIDTH +: CNT_WIDTH]),
            .full      (full),
            .empty     (empty),
            .top_addr  (top_addr),
            .top_cnt   (top_cnt)
        );

        always_comb begin
            state_d = state_q;
            pc_d    = pc_q;
            err_d   = err_q;
            push    = 1'b0;
            pop     = 1'b0;
            dec_top = 1'b0;
            clear   = 1'b0;
            if (stop[i]) begin
                state_d = ST_IDLE;
                pc_d    = RST_PC;
                clear   = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        pc_d = RST_PC;
                        if (start[i]) state_d = ST_FIRST;
                    end
                    // First strobe only primes the instruction fetch.
                    ST_FIRST: begin
                        if (update_pc[i]) state_d = ST_RUN;
                    end
                    ST_RUN: begin
                        if (update_pc[i]) begin
                            case (op[2*i +: 2])
                                OP_SEQ:  pc_d = pc_inc;
                                OP_JUMP: pc_d = jump_target[i*PC_WIDTH +: PC_WIDTH];
                                OP_LOOP_BEGIN: begin
                                    pc_d = pc_inc;
                                    if (full) err_d = 1'b1;
                                    else      push  = 1'b1;
                                end
                                default: begin
                                    if (empty) begin
                                        err_d = 1'b1;
                                        pc_d  = pc_inc;
                                    end else if (top_cnt == '0) begin
                                        pop  = 1'b1;
                                        pc_d = pc_inc;
                                    end else begin
                                        dec_top = 1'b1;
                                        pc_d    = top_addr;
                                    end
                                end
                            endcase
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                pc_q    <= RST_PC;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                pc_q    <= pc_d;
                err_q   <= err_d;
            end
        end

        assign ch_state[i]                   = state_q;
        assign PC[i*PC_WIDTH +: PC_WIDTH]    = pc_q;
        assign running[i]                    = (ch_state[i] != ST_IDLE);
        assign loop_err[i]                   = err_q;
    end

endmodule

// File: tb/tb_pulse_pc_seq.sv
// Bench for pulse_pc_seq: directed vector table plus randomized traffic against a queue-level model.
module tb_pulse_pc_seq;

    localparam int PW = 11;
    localparam int NC = 4;
    localparam int LD = 2;
    localparam int CW = 8;
    localparam int PC_MOD = 1 << PW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     start, stop, update_pc, running, loop_err;
    logic [2*NC-1:0]   op;
    logic [PW*NC-1:0]  jump_target, pc_bus;
    logic [CW*NC-1:0]  loop_count;

    always #5 clk = ~clk;

    pulse_pc_seq #(
        .PC_WIDTH (PW), .NUM_CH (NC), .LOOP_DEPTH (LD), .CNT_WIDTH (CW), .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .update_pc   (update_pc),
        .op          (op),
        .jump_target (jump_target),
        .loop_count  (loop_count),
        .PC          (pc_bus),
        .running     (running),
        .loop_err    (loop_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 armed (waiting for priming strobe), 2 running.
    int m_mode [NC];
    int m_pc   [NC];
    int m_err  [NC];
    int s_n    [NC];
    int s_addr [NC][LD];
    int s_cnt  [NC][LD];

    task automatic check(input string name, input int ch, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s ch%0d got=%0h exp=%0h at %0t", name, ch, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        for (int c = 0; c < NC; c++) begin
            int o;
            o = int'(op[2*c +: 2]);
            if (rst) begin
                m_mode[c] = 0; m_pc[c] = 0; m_err[c] = 0; s_n[c] = 0;
            end else if (stop[c]) begin
                m_mode[c] = 0; m_pc[c] = 0; s_n[c] = 0;
            end else if (m_mode[c] == 0) begin
                if (start[c]) m_mode[c] = 1;
            end else if (m_mode[c] == 1) begin
                if (update_pc[c]) m_mode[c] = 2;
            end else if (update_pc[c]) begin
                if (o == 0) begin
                    m_pc[c] = (m_pc[c] + 1) % PC_MOD;
                end else if (o == 1) begin
                    m_pc[c] = int'(jump_target[c*PW +: PW]);
                end else if (o == 2) begin
                    if (s_n[c] == LD) m_err[c] = 1;
                    else begin
                        s_addr[c][s_n[c]] = (m_pc[c] + 1) % PC_MOD;
                        s_cnt[c][s_n[c]]  = int'(loop_count[c*CW +: CW]);
                        s_n[c]++;
                    end
                    m_pc[c] = (m_pc[c] + 1) % PC_MOD;
                end else if (s_n[c] == 0) begin
                    m_err[c] = 1;
                    m_pc[c]  = (m_pc[c] + 1) % PC_MOD;
                end else if (s_cnt[c][s_n[c]-1] == 0) begin
                    s_n[c]--;
                    m_pc[c] = (m_pc[c] + 1) % PC_MOD;
                end else begin
                    s_cnt[c][s_n[c]-1]--;
                    m_pc[c] = s_addr[c][s_n[c]-1];
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < NC; c++) begin
            check("model_pc", c, int'(pc_bus[c*PW +: PW]), m_pc[c]);
            check("model_running", c, int'(running[c]), (m_mode[c] != 0) ? 1 : 0);
            check("model_loop_err", c, int'(loop_err[c]), m_err[c]);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; start = '0; stop = '0; update_pc = '0;
        op = '0; jump_target = '0; loop_count = '0;
    endtask

    typedef struct {
        int         ch;
        bit         r, st, sp, up;
        logic [1:0] o;
        int         tgt, cnt;
        int         e_pc;
        bit         e_run, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int ch, bit r, bit st, bit sp, bit up, logic [1:0] o,
                                int tgt, int cnt, int e_pc, bit e_run, bit e_err);
        vec_t v;
        v.ch = ch; v.r = r; v.st = st; v.sp = sp; v.up = up; v.o = o;
        v.tgt = tgt; v.cnt = cnt; v.e_pc = e_pc; v.e_run = e_run; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        for (int c = 0; c < NC; c++) begin
            check("reset_pc", c, int'(pc_bus[c*PW +: PW]), 0);
            check("reset_running", c, int'(running[c]), 0);
        end

        // ch0: arm, priming strobe swallowed, then three increments
        add(0, 0, 1, 0, 0, 2'b00, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 1, 2'b00, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 1, 2'b00, 0, 0,     1, 1, 0);
        add(0, 0, 0, 0, 1, 2'b00, 0, 0,     2, 1, 0);
        add(0, 0, 0, 0, 1, 2'b00, 0, 0,     3, 1, 0);
        // ch1: jumps, wrap at top of PC space, stall
        add(1, 0, 1, 0, 0, 2'b00, 0, 0,     0, 1, 0);
        add(1, 0, 0, 0, 1, 2'b00, 0, 0,     0, 1, 0);
        add(1, 0, 0, 0, 1, 2'b01, 5, 0,     5, 1, 0);
        add(1, 0, 0, 0, 1, 2'b01, 'h40, 0,  'h40, 1, 0);
        add(1, 0, 0, 0, 1, 2'b01, 'h7FF, 0, 'h7FF, 1, 0);
        add(1, 0, 0, 0, 1, 2'b00, 0, 0,     0, 1, 0);
        add(1, 0, 0, 0, 1, 2'b00, 0, 0,     1, 1, 0);
        add(1, 0, 0, 0, 0, 2'b00, 0, 0,     1, 1, 0);
        // ch2: loop body run three times, then empty-stack LOOP_END, stop+start, idle strobe
        add(2, 0, 1, 0, 0, 2'b00, 0, 0,     0, 1, 0);
        add(2, 0, 0, 0, 1, 2'b00, 0, 0,     0, 1, 0);
        add(2, 0, 0, 0, 1, 2'b01, 10, 0,    10, 1, 0);
        add(2, 0, 0, 0, 1, 2'b10, 0, 2,     11, 1, 0);
        add(2, 0, 0, 0, 1, 2'b00, 0, 0,     12, 1, 0);
        add(2, 0, 0, 0, 1, 2'b11, 0, 0,     11, 1, 0);
        add(2, 0, 0, 0, 1, 2'b00, 0, 0,     12, 1, 0);
        add(2, 0, 0, 0, 1, 2'b11, 0, 0,     11, 1, 0);
        add(2, 0, 0, 0, 1, 2'b00, 0, 0,     12, 1, 0);
        add(2, 0, 0, 0, 1, 2'b11, 0, 0,     13, 1, 0);
        add(2, 0, 0, 0, 1, 2'b11, 0, 0,     14, 1, 1);
        add(2, 0, 1, 1, 0, 2'b00, 0, 0,     0, 0, 1);
        add(2, 0, 0, 0, 1, 2'b00, 0, 0,     0, 0, 1);
        // ch3: nested loops, then overflow on third push
        add(3, 0, 1, 0, 0, 2'b00, 0, 0,     0, 1, 0);
        add(3, 0, 0, 0, 1, 2'b00, 0, 0,     0, 1, 0);
        add(3, 0, 0, 0, 1, 2'b10, 0, 1,     1, 1, 0);
        add(3, 0, 0, 0, 1, 2'b10, 0, 1,     2, 1, 0);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     2, 1, 0);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     3, 1, 0);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     1, 1, 0);
        add(3, 0, 0, 0, 1, 2'b10, 0, 1,     2, 1, 0);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     2, 1, 0);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     3, 1, 0);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     4, 1, 0);
        add(3, 0, 0, 0, 1, 2'b10, 0, 1,     5, 1, 0);
        add(3, 0, 0, 0, 1, 2'b10, 0, 1,     6, 1, 0);
        add(3, 0, 0, 0, 1, 2'b10, 0, 1,     7, 1, 1);
        add(3, 0, 0, 0, 1, 2'b11, 0, 0,     6, 1, 1);

        foreach (vecs[k]) begin
            clear_inputs();
            rst                               = vecs[k].r;
            start[vecs[k].ch]                 = vecs[k].st;
            stop[vecs[k].ch]                  = vecs[k].sp;
            update_pc[vecs[k].ch]             = vecs[k].up;
            op[2*vecs[k].ch +: 2]             = vecs[k].o;
            jump_target[vecs[k].ch*PW +: PW]  = PW'(vecs[k].tgt);
            loop_count[vecs[k].ch*CW +: CW]   = CW'(vecs[k].cnt);
            tick();
            check("vec_pc", vecs[k].ch, int'(pc_bus[vecs[k].ch*PW +: PW]), vecs[k].e_pc);
            check("vec_running", vecs[k].ch, int'(running[vecs[k].ch]), int'(vecs[k].e_run));
            check("vec_loop_err", vecs[k].ch, int'(loop_err[vecs[k].ch]), int'(vecs[k].e_err));
        end

        // Reset in the middle of loops on every running channel, then strobes must be ignored.
        clear_inputs();
        start[2] = 1'b1;
        tick();
        clear_inputs();
        update_pc = '1;
        op = {2'b10, 2'b10, 2'b10, 2'b10};
        loop_count = {4{8'd3}};
        tick();
        tick();
        clear_inputs();
        rst = 1'b1;
        update_pc = '1;
        tick();
        for (int c = 0; c < NC; c++) begin
            check("rst_mid_pc", c, int'(pc_bus[c*PW +: PW]), 0);
            check("rst_mid_running", c, int'(running[c]), 0);
            check("rst_mid_loop_err", c, int'(loop_err[c]), 0);
        end
        clear_inputs();
        update_pc = '1;
        tick();
        for (int c = 0; c < NC; c++) begin
            check("post_rst_ignore", c, int'(pc_bus[c*PW +: PW]), 0);
        end

        // Randomized traffic on all channels.
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NC; c++) begin
                start[c]     = ($urandom_range(0, 7) == 0);
                stop[c]      = ($urandom_range(0, 59) == 0);
                update_pc[c] = ($urandom_range(0, 3) != 0);
                op[2*c +: 2] = 2'($urandom_range(0, 3));
                jump_target[c*PW +: PW] = ($urandom_range(0, 1) == 0)
                                          ? PW'($urandom_range(2040, 2047))
                                          : PW'($urandom_range(0, 2047));
                loop_count[c*CW +: CW]  = CW'($urandom_range(0, 3));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
